// File: rtl/ustbuf_pkg.sv
// Shared types for the uncached store buffer.
// Posted stores are enabled by defining UNCACHED_STORE_BUF_EN.
package ustbuf_pkg;

   localparam int USTBUF_DEPTH = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } ustbuf_entry_t;

`ifdef UNCACHED_STORE_BUF_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_STORE,
      S_LOAD
   } ustbuf_state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_PASS
   } ustbuf_state_t;
`endif

   function automatic ustbuf_entry_t to_entry(input dbus_req_t r);
      ustbuf_entry_t e;
      e.addr   = r.addr;
      e.size   = r.size;
      e.strobe = r.strobe;
      e.data   = r.data;
      return e;
   endfunction

   function automatic dbus_req_t to_req(input ustbuf_entry_t e);
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = e.addr;
      r.size   = e.size;
      r.strobe = e.strobe;
      r.data   = e.data;
      return r;
   endfunction

endpackage

// File: rtl/ustbuf_fifo.sv
// Circular FIFO of posted uncached stores.
// Only instantiated when UNCACHED_STORE_BUF_EN is defined.
module ustbuf_fifo
   import ustbuf_pkg::*;
#(
   parameter int  DEPTH = USTBUF_DEPTH,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push,
   input  logic          pop,
   input  ustbuf_entry_t wdata,
   output ustbuf_entry_t head,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count
);

   ustbuf_entry_t mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          do_push;
   logic          do_pop;

   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uncached_store_buffer.sv
// Posted-write buffer for the uncached dbus path (UNCACHED_STORE_BUF_EN);
// without the macro it is a one-outstanding registered pass-through.
module uncached_store_buffer
   import ustbuf_pkg::*;
#(
   parameter int DEPTH = USTBUF_DEPTH
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  ureq,
   output dbus_resp_t uresp,
   output dbus_req_t  dreq,
   input  dbus_resp_t dresp
);

   ustbuf_state_t state;
   dbus_req_t     issue_q;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end

   assign dreq = issue_q;

`ifdef UNCACHED_STORE_BUF_EN
   localparam int PW = $clog2(DEPTH);

   logic          is_store;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [PW:0]   count;
   ustbuf_entry_t head;

   assign is_store = |ureq.strobe;
   assign push     = ureq.valid & is_store & ~full;
   assign pop      = (state == S_STORE) & dresp.data_ok;

   ustbuf_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .push  (push),
      .pop   (pop),
      .wdata (to_entry(ureq)),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Stores are acked on accept; loads see the downstream reply.
   always_comb begin
      uresp = '0;
      if (push) begin
         uresp.addr_ok = 1'b1;
         uresp.data_ok = 1'b1;
      end else if (state == S_LOAD) begin
         uresp = dresp;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         issue_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  state   <= S_STORE;
                  issue_q <= to_req(head);
               end else if (count == '0 && ureq.valid && !is_store) begin
                  state   <= S_LOAD;
                  issue_q <= to_req(to_entry(ureq));
               end
            end
            S_STORE, S_LOAD: begin
               if (dresp.data_ok) begin
                  state   <= S_IDLE;
                  issue_q <= '0;
               end
            end
            default: begin
               state   <= S_IDLE;
               issue_q <= '0;
            end
         endcase
      end
   end
`else
   always_comb begin
      uresp = '0;
      if (state == S_PASS) uresp = dresp;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         issue_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (ureq.valid) begin
                  state   <= S_PASS;
                  issue_q <= to_req(to_entry(ureq));
               end
            end
            S_PASS: begin
               if (dresp.data_ok) begin
                  state   <= S_IDLE;
                  issue_q <= '0;
               end
            end
            default: begin
               state   <= S_IDLE;
               issue_q <= '0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Bench for uncached_store_buffer: vector table, corner sequences and
// random traffic against a transaction-level model of the buffer.
module tb_uncached_store_buffer;
   import ustbuf_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      bit          st;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          lat;
      int          ack_c;
      int          vld_c;
   } vec_t;

   logic       clk;
   logic       resetn;
   dbus_req_t  ureq;
   dbus_req_t  dreq;
   dbus_resp_t uresp;
   dbus_resp_t dresp;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   dbus_req_t exp_q[$];
`ifdef UNCACHED_STORE_BUF_EN
   int pending = 0;
`endif
   logic stall   = 1'b0;
   int   lat_cfg = -1;
   int   dwait;
   int   rnd_lat;
   int   lim;

   dbus_req_t prev_dreq;
   logic      prev_dn;
   logic      dn;
   logic      ds_store;
   logic      exp_ack;
   dbus_req_t e;
   int        last_st_done = -1;
   int        ld_issue     = -1;

   uncached_store_buffer #(
      .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .ureq  (ureq),
      .uresp (uresp),
      .dreq  (dreq),
      .dresp (dresp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Downstream converter: replies a number of cycles after valid.
   initial begin
      dresp   = '0;
      dwait   = 0;
      rnd_lat = 1;
      forever begin
         @(posedge clk);
         #2;
         dresp = '0;
         if (!resetn || !dreq.valid) begin
            dwait = 0;
         end else if (!stall) begin
            lim = (lat_cfg < 0) ? rnd_lat : lat_cfg;
            if (dwait >= lim) begin
               dresp.addr_ok = 1'b1;
               dresp.data_ok = 1'b1;
               dresp.data    = $urandom;
               dwait         = 0;
               rnd_lat       = $urandom_range(0, 3);
            end else begin
               dwait++;
            end
         end
      end
   end

   // Model: downstream sees every request once, in program order;
   // posted stores ack while fewer than DEPTH are outstanding.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_q.delete();
`ifdef UNCACHED_STORE_BUF_EN
         pending = 0;
`endif
         prev_dreq = '0;
         prev_dn   = 1'b0;
      end else begin
         dn       = dresp.data_ok;
         ds_store = 1'b0;
         exp_ack  = 1'b0;
         if (dn) begin
            if (exp_q.size() == 0) begin
               chk("down_extra", dreq, '0);
            end else begin
               e = exp_q.pop_front();
               chk("down_order", dreq, e);
               ds_store = (e.strobe != 4'h0);
               if (ds_store) last_st_done = cyc;
            end
         end
         if (dreq.valid && dreq.strobe == 4'h0 && !prev_dreq.valid)
            ld_issue = cyc;
         if (prev_dreq.valid && !prev_dn)
            chk("dreq_hold", dreq, prev_dreq);
         prev_dreq = dreq;
         prev_dn   = dn;
         if (ureq.valid) begin
`ifdef UNCACHED_STORE_BUF_EN
            if (ureq.strobe != 4'h0) exp_ack = (pending < DEPTH);
            else exp_ack = dn && !ds_store;
`else
            exp_ack = dn;
`endif
         end
         chk("uresp_data_ok", uresp.data_ok, exp_ack);
         chk("uresp_addr_ok", uresp.addr_ok, exp_ack);
         if (!exp_ack) chk("uresp_idle", uresp, '0);
         else if (ureq.strobe == 4'h0) chk("load_data", uresp.data, dresp.data);
`ifdef UNCACHED_STORE_BUF_EN
         if (ureq.valid && ureq.strobe != 4'h0 && exp_ack) pending++;
         if (ds_store) pending--;
`endif
      end
   end

   function automatic dbus_req_t mk(input bit st, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
      dbus_req_t r;
      r        = '0;
      r.valid  = 1'b1;
      r.addr   = a;
      r.size   = 3'd2;
      r.strobe = st ? s : 4'h0;
      r.data   = d;
      return r;
   endfunction

   function automatic dbus_req_t rnd_req();
      dbus_req_t r;
      bit st;
      st     = 1'($urandom_range(0, 1));
      r      = mk(st, 32'hA000_0000 | ($urandom & 32'h1FFF_FFFC), $urandom,
                  4'($urandom_range(1, 15)));
      r.size = 3'($urandom_range(0, 2));
      return r;
   endfunction

   task automatic present(input dbus_req_t r);
      ureq       = r;
      ureq.valid = 1'b1;
      exp_q.push_back(ureq);
   endtask

   task automatic wait_ack(input int max, output int got);
      got = -1;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (uresp.data_ok) got = k;
         @(posedge clk);
         #1;
         if (got >= 0) begin
            ureq.valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain(input int max);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || dreq.valid) && k < max) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_done", 128'(exp_q.size()), 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t tbl[5];
      int   a;
      int   v;
      int   got;
      int   vcnt;
      int   nst;

`ifdef UNCACHED_STORE_BUF_EN
      tbl[0] = '{1'b1, 32'hBFAF_F000, 32'h0000_1234, 4'hF, 3, 0, 2};
      tbl[1] = '{1'b0, 32'hBFAF_F010, 32'h0, 4'h0, 0, 1, 1};
      tbl[2] = '{1'b1, 32'hA000_0004, 32'hDEAD_BEEF, 4'h2, 1, 0, 2};
      tbl[3] = '{1'b0, 32'hA000_0008, 32'h0, 4'h0, 2, 3, 1};
      tbl[4] = '{1'b1, 32'hBFFF_FFFC, 32'h0000_CAFE, 4'hF, 0, 0, 2};
      nst    = 3;
`else
      tbl[0] = '{1'b1, 32'hBFAF_F000, 32'h0000_1234, 4'hF, 3, 4, 1};
      tbl[1] = '{1'b0, 32'hBFAF_F010, 32'h0, 4'h0, 0, 1, 1};
      tbl[2] = '{1'b1, 32'hA000_0004, 32'hDEAD_BEEF, 4'h2, 1, 2, 1};
      tbl[3] = '{1'b0, 32'hA000_0008, 32'h0, 4'h0, 2, 3, 1};
      tbl[4] = '{1'b1, 32'hBFFF_FFFC, 32'h0000_CAFE, 4'hF, 0, 1, 1};
      nst    = 1;
`endif

      ureq   = '0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_dreq", dreq, '0);
      chk("reset_uresp", uresp, '0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Single transactions: ack and issue cycle relative to presentation.
      for (int i = 0; i < 5; i++) begin
         lat_cfg = tbl[i].lat;
         present(mk(tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].strb));
         a = -1;
         v = -1;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (uresp.data_ok && a < 0) a = k;
            if (dreq.valid && v < 0) v = k;
            @(posedge clk);
            #1;
            if (a >= 0) ureq.valid = 1'b0;
         end
         chk("vec_ack_cycle", a, tbl[i].ack_c);
         chk("vec_issue_cycle", v, tbl[i].vld_c);
      end
      drain(50);

      // Two stores then a load: the load issues after the last store.
      lat_cfg      = 2;
      last_st_done = -1;
      ld_issue     = -1;
      present(mk(1'b1, 32'hBFAF_F000, 32'h1111_0001, 4'hF));
      wait_ack(20, got);
      chk("seq_st1_ack", got >= 0, 1);
      present(mk(1'b1, 32'hBFAF_F004, 32'h1111_0002, 4'h3));
      wait_ack(20, got);
      chk("seq_st2_ack", got >= 0, 1);
      present(mk(1'b0, 32'hBFAF_F010, 32'h0, 4'h0));
      wait_ack(40, got);
      chk("seq_ld_ack", got >= 0, 1);
      chk("load_after_stores", ld_issue > last_st_done && last_st_done >= 0, 1);
      drain(50);

`ifdef UNCACHED_STORE_BUF_EN
      // Fill with downstream stalled; fifth store waits for a pop.
      stall   = 1'b1;
      lat_cfg = 0;
      for (int i = 0; i < 4; i++) begin
         present(mk(1'b1, 32'hB000_0000 + 32'(4 * i), 32'(i + 1), 4'hF));
         wait_ack(1, got);
         chk("fill_ack", got, 0);
      end
      present(mk(1'b1, 32'hB000_0010, 32'd5, 4'hF));
      wait_ack(6, got);
      chk("full_stall", got, -1);
      stall = 1'b0;
      @(negedge clk);
      chk("pop_seen", dresp.data_ok, 1);
      chk("full_pop_noack", uresp.data_ok, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("accept_after_pop", uresp.data_ok, 1);
      @(posedge clk);
      #1;
      ureq.valid = 1'b0;
      drain(100);
`endif

      // Reset while work is in flight discards it.
      stall   = 1'b1;
      lat_cfg = 0;
      for (int i = 0; i < nst; i++) begin
         present(mk(1'b1, 32'hBF00_0000 + 32'(4 * i), 32'hAB00 + 32'(i), 4'hF));
`ifdef UNCACHED_STORE_BUF_EN
         wait_ack(2, got);
         chk("rst_fill_ack", got, 0);
`endif
      end
      for (int k = 0; k < 6 && !dreq.valid; k++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_in_flight", dreq.valid, 1);
      ureq.valid = 1'b0;
      resetn     = 1'b0;
      @(negedge clk);
      chk("rst_dreq", dreq, '0);
      chk("rst_uresp", uresp, '0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      stall  = 1'b0;
      vcnt   = 0;
      repeat (10) begin
         @(negedge clk);
         if (dreq.valid) vcnt++;
      end
      chk("rst_no_replay", vcnt, 0);
      @(posedge clk);
      #1;

      // Random traffic against the model.
      lat_cfg = -1;
      for (int i = 0; i < 250; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         present(rnd_req());
         wait_ack(100, got);
         chk("rand_ack_timeout", got >= 0, 1);
         if (got < 0) ureq.valid = 1'b0;
      end
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
